// File: rtl/crc_frame_checker.sv
// Receive-side CRC-8 frame checker: residue check over each framed byte stream,
// registered pass/fail report one cycle after the frame ends, saturating statistics.
module crc_frame_checker #(
  parameter int                WIDTH   = 8,
  parameter logic [WIDTH-1:0]  POLY    = 8'h07,
  parameter int                MAX_LEN = 1024,
  parameter int                CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_valid,
  input  logic             data_sof,
  input  logic             data_eof,
  input  logic [7:0]       data_in,
  output logic             busy,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic [1:0]       err_code,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {IDLE, BODY} state_t;

  localparam logic [15:0] MAX_LEN_L = 16'(MAX_LEN);

  function automatic logic [WIDTH-1:0] crc_byte(input logic [WIDTH-1:0] crc_in,
                                                input logic [7:0] d_in);
    logic [WIDTH-1:0] c;
    logic [7:0]       d;
    c = crc_in;
    d = d_in;
    for (int i = 0; i < 8; i++) begin
      if (c[WIDTH-1] ^ d[7]) c = (c << 1) ^ POLY;
      else                   c = c << 1;
      d = d << 1;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] crc_q, crc_d, crc_nxt, crc_new;
  logic [15:0]      len_q, len_d, len_inc;
  logic             pend_q, pend_d;
  logic             rep;
  logic [1:0]       rep_code;
  logic [15:0]      rep_len;

  assign crc_nxt = crc_byte(crc_q, data_in);
  assign crc_new = crc_byte('0, data_in);
  assign len_inc = len_q + 16'd1;
  assign busy    = (state_q == BODY);

  // pend_q carries the single-byte runt left behind by a sof+eof that aborted a frame
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    len_d    = len_q;
    pend_d   = 1'b0;
    rep      = 1'b0;
    rep_code = 2'd0;
    rep_len  = 16'd0;
    if (pend_q) begin
      rep      = 1'b1;
      rep_code = 2'd2;
      rep_len  = 16'd1;
    end
    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (data_sof) begin
            crc_d = crc_new;
            len_d = 16'd1;
            if (data_eof) begin
              if (pend_q) begin
                pend_d = 1'b1;
              end else begin
                rep      = 1'b1;
                rep_code = 2'd2;
                rep_len  = 16'd1;
              end
            end else begin
              state_d = BODY;
            end
          end
        end
        BODY: begin
          if (data_sof) begin
            rep      = 1'b1;
            rep_code = 2'd3;
            rep_len  = len_q;
            crc_d    = crc_new;
            len_d    = 16'd1;
            if (data_eof) begin
              pend_d  = 1'b1;
              state_d = IDLE;
            end
          end else if (len_q >= MAX_LEN_L) begin
            rep      = 1'b1;
            rep_code = 2'd3;
            rep_len  = MAX_LEN_L;
            state_d  = IDLE;
          end else begin
            crc_d = crc_nxt;
            len_d = len_inc;
            if (data_eof) begin
              rep      = 1'b1;
              rep_code = (crc_nxt == '0) ? 2'd0 : 2'd1;
              rep_len  = len_inc;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      crc_q       <= '0;
      len_q       <= 16'd0;
      pend_q      <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      err_code    <= 2'd0;
      frame_len   <= 16'd0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      frame_done <= rep;
      crc_ok     <= rep && (rep_code == 2'd0);
      crc_err    <= rep && (rep_code != 2'd0);
      if (rep) begin
        err_code  <= rep_code;
        frame_len <= rep_len;
        if (frame_count != '1) frame_count <= frame_count + CNT_W'(1);
        if ((rep_code != 2'd0) && (err_count != '1)) err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: a default build plus a MAX_LEN=4 / CNT_W=4
// build for the oversize and saturation cases.
module tb_crc_frame_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, a_sof, a_eof;
  logic [7:0]  a_data;
  logic        a_busy, a_done, a_ok, a_err;
  logic [1:0]  a_code;
  logic [15:0] a_len, a_fcnt, a_ecnt;
  logic        b_valid, b_sof, b_eof;
  logic [7:0]  b_data;
  logic        b_busy, b_done, b_ok, b_err;
  logic [1:0]  b_code;
  logic [15:0] b_len;
  logic [3:0]  b_fcnt, b_ecnt;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  crc_frame_checker dut_a (
    .clk(clk), .reset_n(reset_n), .data_valid(a_valid), .data_sof(a_sof),
    .data_eof(a_eof), .data_in(a_data), .busy(a_busy), .frame_done(a_done),
    .crc_ok(a_ok), .crc_err(a_err), .err_code(a_code), .frame_len(a_len),
    .frame_count(a_fcnt), .err_count(a_ecnt)
  );

  crc_frame_checker #(.MAX_LEN(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .data_valid(b_valid), .data_sof(b_sof),
    .data_eof(b_eof), .data_in(b_data), .busy(b_busy), .frame_done(b_done),
    .crc_ok(b_ok), .crc_err(b_err), .err_code(b_code), .frame_len(b_len),
    .frame_count(b_fcnt), .err_count(b_ecnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compare_cnt++;
    assert (obs === expv) else begin
      mismatch_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one byte into the selected DUT at the falling edge, then samples 1 ns after the rise.
  task automatic apply_stimulus(input bit sel, input bit sof, input bit eof, input logic [7:0] d);
    @(negedge clk);
    a_valid = !sel; a_sof = sof; a_eof = eof; a_data = d;
    b_valid = sel;  b_sof = sof; b_eof = eof; b_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_report(input string tag, input bit sel, input logic [1:0] code,
                              input logic [15:0] len);
    if (!sel) begin
      check_output({tag, ".done"}, a_done, 1);
      check_output({tag, ".ok"},   a_ok,   (code == 2'd0));
      check_output({tag, ".err"},  a_err,  (code != 2'd0));
      check_output({tag, ".code"}, a_code, code);
      check_output({tag, ".len"},  a_len,  len);
    end else begin
      check_output({tag, ".done"}, b_done, 1);
      check_output({tag, ".ok"},   b_ok,   (code == 2'd0));
      check_output({tag, ".err"},  b_err,  (code != 2'd0));
      check_output({tag, ".code"}, b_code, code);
      check_output({tag, ".len"},  b_len,  len);
    end
  endtask

  initial begin
    logic [7:0] msg [10];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    reset_n = 1'b0;
    a_valid = 0; a_sof = 0; a_eof = 0; a_data = 0;
    b_valid = 0; b_sof = 0; b_eof = 0; b_data = 0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst.busy", a_busy, 0);
    check_output("rst.done", a_done, 0);
    check_output("rst.ok",   a_ok,   0);
    check_output("rst.err",  a_err,  0);
    check_output("rst.code", a_code, 0);
    check_output("rst.len",  a_len,  0);
    check_output("rst.fcnt", a_fcnt, 0);
    check_output("rst.ecnt", a_ecnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // "123456789" with its CRC 0xF4 leaves a zero residue
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, (i == 0), (i == 9), msg[i]);
      if (i == 4) check_output("std.busy_mid", a_busy, 1);
      if (i < 9)  check_output("std.no_done", a_done, 0);
    end
    check_report("std", 0, 2'd0, 16'd10);
    check_output("std.fcnt", a_fcnt, 1);
    check_output("std.busy", a_busy, 0);
    idle_cycle();
    check_output("std.pulse", a_done, 0);
    check_output("std.hold",  a_len,  10);

    apply_stimulus(0, 1, 0, 8'h01);
    apply_stimulus(0, 0, 1, 8'h07);
    check_report("good2", 0, 2'd0, 16'd2);
    apply_stimulus(0, 1, 0, 8'h01);
    check_output("b2b.clear", a_done, 0);
    apply_stimulus(0, 0, 1, 8'h08);
    check_report("bad2", 0, 2'd1, 16'd2);
    check_output("bad2.fcnt", a_fcnt, 3);
    check_output("bad2.ecnt", a_ecnt, 1);

    apply_stimulus(0, 1, 1, 8'h00);
    check_report("runt", 0, 2'd2, 16'd1);
    check_output("runt.ecnt", a_ecnt, 2);
    apply_stimulus(0, 0, 0, 8'h55);
    check_output("drop.done", a_done, 0);
    check_output("drop.fcnt", a_fcnt, 4);
    check_output("drop.busy", a_busy, 0);

    // asynchronous reset in the middle of a frame
    apply_stimulus(0, 1, 0, 8'h01);
    apply_stimulus(0, 0, 0, 8'h02);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mrst.busy", a_busy, 0);
    check_output("mrst.fcnt", a_fcnt, 0);
    check_output("mrst.len",  a_len,  0);
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(0, 1, 0, 8'h01);
    apply_stimulus(0, 0, 1, 8'h07);
    check_report("post", 0, 2'd0, 16'd2);
    check_output("post.fcnt", a_fcnt, 1);

    apply_stimulus(0, 1, 0, 8'hAA);
    apply_stimulus(0, 0, 0, 8'hBB);
    apply_stimulus(0, 1, 0, 8'h01);
    check_report("abort", 0, 2'd3, 16'd2);
    check_output("abort.busy", a_busy, 1);
    apply_stimulus(0, 0, 1, 8'h07);
    check_report("abort_new", 0, 2'd0, 16'd2);
    check_output("abort.fcnt", a_fcnt, 3);
    check_output("abort.ecnt", a_ecnt, 1);

    // sof+eof while a frame is open: abort now, runt one cycle later
    apply_stimulus(0, 1, 0, 8'h05);
    apply_stimulus(0, 1, 1, 8'h00);
    check_report("ab_se", 0, 2'd3, 16'd1);
    idle_cycle();
    check_report("ab_se_runt", 0, 2'd2, 16'd1);
    check_output("ab_se.fcnt", a_fcnt, 5);
    check_output("ab_se.ecnt", a_ecnt, 3);
    idle_cycle();
    check_output("ab_se.pulse", a_done, 0);

    // oversize on the MAX_LEN=4 build
    apply_stimulus(1, 1, 0, 8'h10);
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1, 0, 0, 8'(8'h10 + i));
      if (i < 4) check_output("ovs.no_done", b_done, 0);
    end
    check_report("ovs", 1, 2'd3, 16'd4);
    check_output("ovs.busy", b_busy, 0);
    apply_stimulus(1, 0, 0, 8'h15);
    check_output("ovs.drop", b_done, 0);
    check_output("ovs.fcnt", b_fcnt, 1);

    // fill the 4-bit counters with runts, then confirm saturation
    for (int i = 0; i < 14; i++) apply_stimulus(1, 1, 1, 8'h00);
    check_output("sat.fcnt_full", b_fcnt, 15);
    check_output("sat.ecnt_full", b_ecnt, 15);
    apply_stimulus(1, 1, 0, 8'h01);
    apply_stimulus(1, 0, 1, 8'h07);
    check_report("sat", 1, 2'd0, 16'd2);
    check_output("sat.fcnt", b_fcnt, 15);
    check_output("sat.ecnt", b_ecnt, 15);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/crc_frame_checker.md
# crc_frame_checker

Receive-side companion to the team's byte-wise CRC-8 generator. It consumes a framed byte stream whose final byte is the transmitter's CRC, runs the same CRC-8 (POLY 0x07) over every byte of the frame, and reports pass or fail one cycle after the last byte. It also keeps saturating frame and error statistics for software. It sits between the byte deframer and the packet buffer's commit/discard logic.

## Interface
- WIDTH, 8: CRC width. Only 8 is supported.
- POLY, 8'h07: CRC polynomial, MSB-first, no reflection. Init 0x00, no final XOR.
- MAX_LEN, 1024: maximum frame length in bytes, including the CRC byte.
- CNT_W, 16: width of the statistics counters.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- data_valid  in  1  a byte is presented this cycle. Always accepted; there is no backpressure.
- data_sof  in  1  the byte is the first of a frame. Qualified by data_valid.
- data_eof  in  1  the byte is the last (CRC) byte of a frame. Qualified by data_valid.
- data_in  in  8  frame byte.
- busy  out  1  a frame is open (state BODY).
- frame_done  out  1  one-cycle pulse: result outputs are valid.
- crc_ok  out  1  one-cycle pulse with frame_done: the frame passed.
- crc_err  out  1  one-cycle pulse with frame_done: CRC mismatch, runt, oversize, or abort.
- err_code  out  2  valid with frame_done: 0 = OK, 1 = CRC mismatch, 2 = runt (<2 bytes), 3 = oversize/abort.
- frame_len  out  16  byte count of the reported frame, including the CRC byte. Held until the next frame_done.
- frame_count  out  CNT_W  frames reported. Saturates at all-ones.
- err_count  out  CNT_W  frames reported with crc_err. Saturates at all-ones.

## Operation
- States: IDLE and BODY.
- Residue check: the CRC register is updated over every byte, including the trailing CRC byte. The frame passes when the final residue is 0x00. The byte update is 8 serial steps, MSB first: if crc[7]^d[7], then crc = (crc<<1)^POLY, else crc = crc<<1; then d <<= 1.
- IDLE:
  - data_valid & data_sof: load the CRC with the one-step update of 0x00 with data_in, set len=1, go to BODY.
  - If eof is also set, the frame ends immediately (see the end-of-frame rules).
  - Bytes without sof are dropped silently; counters are unchanged.
- BODY:
  - On each data_valid, update the CRC and increment len.
  - data_valid & data_eof: end of frame; go to IDLE.
  - data_valid & data_sof without eof: abort. Report the old frame with err_code 3, len = bytes received before the sof byte. Restart a new frame with the current byte (CRC from 0x00, len=1) and stay in BODY.
  - data_valid & data_sof & data_eof: report the old frame as abort. The new single-byte frame is reported on the following cycle as a runt.
  - When len would exceed MAX_LEN: report oversize (err_code 3, len = MAX_LEN) and go to DROP-in-IDLE. Remaining bytes up to the next sof are discarded as in IDLE.
- End of frame with len < 2: runt, err_code 2, regardless of residue.
- Error precedence: runt > oversize/abort > CRC mismatch.
- Every report increments frame_count. Every crc_err report also increments err_count. Both counters saturate.

## Timing
- Reset values: busy=0, frame_done=0, crc_ok=0, crc_err=0, err_code=0, frame_len=0, frame_count=0, err_count=0, CRC register=0x00, state IDLE.
- Result latency:
  - frame_done, crc_ok, crc_err, err_code and frame_len are registered.
  - They assert in the cycle after the clock edge that accepted the eof, abort or oversize byte.
  - The counters update on that same edge.
- Back-to-back frames: an eof on cycle N and a sof on cycle N+1 are legal. The frame reported on N+1 is independent of the new frame.
- The data_valid gap between bytes is unbounded; the state is held.
- reset_n assertion mid-frame discards the frame without a report. Outputs return to their reset values immediately (asynchronously).
- Deassert reset_n synchronously to clk (this is the system's responsibility). The first byte can be accepted on the first edge after deassertion.

## Test plan
- "123456789" (0x31–0x39, sof on 0x31) followed by 0xF4 with eof -> one cycle later frame_done=1, crc_ok=1, err_code=0, frame_len=10, frame_count=1.
- Frame {0x01, 0x07} -> crc_ok, len 2. Frame {0x01, 0x08} -> crc_err, err_code 1, err_count=1.
- A single byte 0x00 with both sof and eof -> crc_err, err_code 2, frame_len 1. A byte without sof in IDLE -> no frame_done.
- sof 0xAA, 0xBB, then sof 0x01, 0x07 eof -> abort report (err_code 3, len 2), then crc_ok len 2. frame_count=2, err_count=1.
- MAX_LEN=4 build: sof followed by 5 valid bytes -> oversize report (err_code 3, len 4). The fifth and later bytes are ignored until the next sof.
- Assert reset_n low mid-frame, then send {0x01, 0x07} -> no stale report, crc_ok, frame_count=1. Hold frame_count at 0xFFFF and send a good frame -> frame_count stays 0xFFFF.
